ps2_transmitter: RTL and testbench

PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

---
 rtl/ps2_transmitter_pkg.sv | 52 +++++
 rtl/ps2_line_filter.sv | 63 ++++++
 rtl/ps2_transmitter.sv | 247 ++++++++++++++++++++++++
 tb/tb_ps2_transmitter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_transmitter_pkg.sv
// ----------------------------------------------------------------------------
// ps2_transmitter_pkg
// Shared constants and helpers for the PS/2 host-to-device transmitter:
//   - controller state encoding
//   - PS/2 frame constants (edge numbers, line indices)
//   - odd-parity rule and microsecond-to-cycle conversion
// ----------------------------------------------------------------------------
package ps2_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_INHIBIT      = 3'd1,
        ST_REQUEST      = 3'd2,
        ST_WAIT_EDGE    = 3'd3,
        ST_SHIFT        = 3'd4,
        ST_ACK          = 3'd5,
        ST_WAIT_RELEASE = 3'd6
    } tx_state_e;

    // Host-to-device frame: start, 8 data bits, parity, stop, then device ack.
    // The start bit is driven before clocking begins, so only data, parity
    // and stop are shifted out on device falling edges 1..10.
    localparam int unsigned PS2_DATA_BITS  = 8;
    localparam int unsigned PS2_SHIFT_BITS = PS2_DATA_BITS + 2;
    localparam logic [3:0]  PS2_STOP_EDGE  = 4'd10;
    localparam logic [3:0]  PS2_ACK_EDGE   = 4'd11;

    // Index of each physical line inside the filtered line vectors.
    localparam int unsigned PS2_LINES     = 2;
    localparam int unsigned PS2_LINE_CLK  = 0;
    localparam int unsigned PS2_LINE_DATA = 1;

    // PS/2 uses odd parity: the parity bit makes the count of ones odd.
    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // 64-bit arithmetic: 108 MHz * 15 ms overflows 32 bits.
    function automatic logic [63:0] us_to_cycles(input logic [63:0] us,
                                                 input logic [63:0] hz);
        return (us * hz) / 64'd1_000_000;
    endfunction

    function automatic logic [63:0] max3(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic [63:0] c);
        logic [63:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ----------------------------------------------------------------------------
// ps2_line_filter
// Brings one raw PS/2 pin into the clk domain and removes glitches.
// A 2-flop synchronizer is followed by a stability filter: the output level
// only changes after FILTER_CYCLES consecutive synchronized samples disagree
// with it. Reset leaves the filter at the idle (released, high) level.
//
// Ports
//   clk     in   system clock
//   reset   in   asynchronous active-high reset
//   raw_in  in   raw, asynchronous pin level
//   level   out  filtered, registered line level
// ----------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level
);

    localparam int unsigned CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
        end
    end

    // cnt_reg holds how many consecutive samples so far disagreed with the
    // current level; any agreeing sample restarts the run.
    always_comb begin
        level_next = level_reg;
        cnt_next   = '0;
        if (sync2_reg != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = sync2_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/ps2_transmitter.sv
// ----------------------------------------------------------------------------
// ps2_transmitter
// PS/2 host-to-device byte transmitter. Inhibits the bus, issues the
// request-to-send, shifts out data/parity/stop on device clock falling edges,
// checks the device acknowledge and waits for the bus to be released.
//
// Ports
//   clk                  in   system clock
//   reset                in   asynchronous active-high reset
//   tx_data[7:0]         in   byte to send
//   tx_start             in   send request, honoured only while tx_ready=1
//   tx_ready             out  idle and able to accept tx_start
//   tx_done_tick         out  1-cycle pulse: frame sent and acknowledged
//   tx_error             out  1-cycle pulse: timeout or missing ack
//   busy                 out  transfer in progress (gates the receiver)
//   ps2_clock_in         in   raw PS/2 clock pin level
//   ps2_data_in          in   raw PS/2 data pin level
//   ps2_clock_drive_low  out  1 = pull PS/2 clock low
//   ps2_data_drive_low   out  1 = pull PS/2 data low
// ----------------------------------------------------------------------------
module ps2_transmitter
    import ps2_transmitter_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY_HZ      = 108_000_000,
    parameter int unsigned INHIBIT_US            = 100,
    parameter int unsigned FIRST_EDGE_TIMEOUT_US = 15_000,
    parameter int unsigned FRAME_TIMEOUT_US      = 2_000,
    parameter int unsigned FILTER_CYCLES         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_done_tick,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_drive_low,
    output logic       ps2_data_drive_low
);

    localparam logic [63:0] INHIBIT_CYCLES =
        us_to_cycles(64'(INHIBIT_US), 64'(CLK_FREQUENCY_HZ));
    localparam logic [63:0] FIRST_EDGE_CYCLES =
        us_to_cycles(64'(FIRST_EDGE_TIMEOUT_US), 64'(CLK_FREQUENCY_HZ));
    localparam logic [63:0] FRAME_CYCLES =
        us_to_cycles(64'(FRAME_TIMEOUT_US), 64'(CLK_FREQUENCY_HZ));
    localparam logic [63:0] MAX_CYCLES =
        max3(INHIBIT_CYCLES, FIRST_EDGE_CYCLES, FRAME_CYCLES);

    // The timer never counts past (longest timeout - 1), so clog2 bits suffice.
    localparam int unsigned TIMER_W = (MAX_CYCLES > 64'd1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TIMER_W-1:0] INHIBIT_LAST    = TIMER_W'(INHIBIT_CYCLES - 64'd1);
    localparam logic [TIMER_W-1:0] FIRST_EDGE_LAST = TIMER_W'(FIRST_EDGE_CYCLES - 64'd1);
    localparam logic [TIMER_W-1:0] FRAME_LAST      = TIMER_W'(FRAME_CYCLES - 64'd1);

    // ------------------------------------------------------------------
    // Input conditioning: one filter per line, clock at index 0
    // ------------------------------------------------------------------
    logic [PS2_LINES-1:0] line_raw;
    logic [PS2_LINES-1:0] line_level;

    assign line_raw[PS2_LINE_CLK]  = ps2_clock_in;
    assign line_raw[PS2_LINE_DATA] = ps2_data_in;

    genvar gi;
    generate
        for (gi = 0; gi < PS2_LINES; gi = gi + 1) begin : g_filter
            ps2_line_filter #(
                .FILTER_CYCLES(FILTER_CYCLES)
            ) u_filter (
                .clk    (clk),
                .reset  (reset),
                .raw_in (line_raw[gi]),
                .level  (line_level[gi])
            );
        end
    endgenerate

    // Falling edge of the filtered clock; the raw pin is never used for edges.
    logic clk_level_prev_reg;
    logic clk_fall;

    assign clk_fall = clk_level_prev_reg & ~line_level[PS2_LINE_CLK];

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    tx_state_e                 state_reg,           state_next;
    logic [TIMER_W-1:0]        timer_reg,           timer_next;
    logic [3:0]                edge_cnt_reg,        edge_cnt_next;
    logic [PS2_SHIFT_BITS-1:0] shift_reg,           shift_next;
    logic                      clock_drive_low_reg, clock_drive_low_next;
    logic                      data_drive_low_reg,  data_drive_low_next;
    logic                      tx_ready_reg,        tx_ready_next;
    logic                      busy_reg,            busy_next;
    logic                      done_reg,            done_next;
    logic                      error_reg,           error_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg           <= ST_IDLE;
            timer_reg           <= '0;
            edge_cnt_reg        <= '0;
            shift_reg           <= '0;
            clock_drive_low_reg <= 1'b0;
            data_drive_low_reg  <= 1'b0;
            tx_ready_reg        <= 1'b1;
            busy_reg            <= 1'b0;
            done_reg            <= 1'b0;
            error_reg           <= 1'b0;
            clk_level_prev_reg  <= 1'b1;
        end else begin
            state_reg           <= state_next;
            timer_reg           <= timer_next;
            edge_cnt_reg        <= edge_cnt_next;
            shift_reg           <= shift_next;
            clock_drive_low_reg <= clock_drive_low_next;
            data_drive_low_reg  <= data_drive_low_next;
            tx_ready_reg        <= tx_ready_next;
            busy_reg            <= busy_next;
            done_reg            <= done_next;
            error_reg           <= error_next;
            clk_level_prev_reg  <= line_level[PS2_LINE_CLK];
        end
    end

    always_comb begin
        state_next           = state_reg;
        timer_next           = timer_reg + TIMER_W'(1);
        edge_cnt_next        = edge_cnt_reg;
        shift_next           = shift_reg;
        clock_drive_low_next = 1'b0;
        data_drive_low_next  = data_drive_low_reg;
        done_next            = 1'b0;
        error_next           = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                timer_next          = '0;
                edge_cnt_next       = '0;
                data_drive_low_next = 1'b0;
                if (tx_start && tx_ready_reg) begin
                    // Frame shifted LSB first: data, parity, stop (1).
                    shift_next           = {1'b1, ps2_odd_parity(tx_data), tx_data};
                    clock_drive_low_next = 1'b1;
                    state_next           = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                clock_drive_low_next = 1'b1;
                data_drive_low_next  = 1'b0;
                if (timer_reg == INHIBIT_LAST) begin
                    // Start bit goes low while the clock is still held.
                    data_drive_low_next = 1'b1;
                    state_next          = ST_REQUEST;
                end
            end

            ST_REQUEST: begin
                // Release the clock; the first-edge timer counts from here.
                data_drive_low_next = 1'b1;
                timer_next          = '0;
                state_next          = ST_WAIT_EDGE;
            end

            ST_WAIT_EDGE: begin
                if (clk_fall) begin
                    edge_cnt_next       = 4'd1;
                    data_drive_low_next = ~shift_reg[0];
                    shift_next          = {1'b1, shift_reg[PS2_SHIFT_BITS-1:1]};
                    timer_next          = '0;   // frame timer starts here
                    state_next          = ST_SHIFT;
                end else if (timer_reg == FIRST_EDGE_LAST) begin
                    data_drive_low_next = 1'b0;
                    error_next          = 1'b1;
                    state_next          = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (timer_reg == FRAME_LAST) begin
                    data_drive_low_next = 1'b0;
                    error_next          = 1'b1;
                    state_next          = ST_IDLE;
                end else if (clk_fall) begin
                    // The stop bit is 1, so edge 10 releases the data line.
                    edge_cnt_next       = edge_cnt_reg + 4'd1;
                    data_drive_low_next = ~shift_reg[0];
                    shift_next          = {1'b1, shift_reg[PS2_SHIFT_BITS-1:1]};
                    if (edge_cnt_next == PS2_STOP_EDGE) begin
                        state_next = ST_ACK;
                    end
                end
            end

            ST_ACK: begin
                data_drive_low_next = 1'b0;
                if (timer_reg == FRAME_LAST) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end else if (clk_fall) begin
                    edge_cnt_next = edge_cnt_reg + 4'd1;
                    if (!line_level[PS2_LINE_DATA]) begin
                        state_next = ST_WAIT_RELEASE;
                    end else begin
                        error_next = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_WAIT_RELEASE: begin
                data_drive_low_next = 1'b0;
                if (timer_reg == FRAME_LAST) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end else if (line_level[PS2_LINE_CLK] && line_level[PS2_LINE_DATA]) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                data_drive_low_next = 1'b0;
                state_next          = ST_IDLE;
            end
        endcase

        // Ready is registered together with the return to IDLE, so it is
        // already high during the done/error pulse and on the cycle after.
        tx_ready_next = (state_next == ST_IDLE);
        busy_next     = ~tx_ready_next;
    end

    assign tx_ready            = tx_ready_reg;
    assign busy                = busy_reg;
    assign tx_done_tick        = done_reg;
    assign tx_error            = error_reg;
    assign ps2_clock_drive_low = clock_drive_low_reg;
    assign ps2_data_drive_low  = data_drive_low_reg;

endmodule

// File: tb/tb_ps2_transmitter.sv
// ----------------------------------------------------------------------------
// tb_ps2_transmitter
// Drives ps2_transmitter against a behavioural PS/2 device running a 10 kHz
// clock (100 system cycles at a 1 MHz system clock). Expected outcomes are
// queued when a request is issued; a monitor pops them on each done/error
// pulse and compares with what the device actually received.
// ----------------------------------------------------------------------------
module tb_ps2_transmitter;

    localparam int unsigned CLK_HZ   = 1_000_000;
    localparam int unsigned INH_US   = 100;
    localparam int unsigned FIRST_US = 3_000;
    localparam int unsigned FRAME_US = 2_000;
    localparam int unsigned FILT     = 8;

    localparam int N_INHIBIT = INH_US * (CLK_HZ / 1_000_000);
    localparam int M_FIRST   = FIRST_US * (CLK_HZ / 1_000_000);

    localparam int MODE_ACK     = 0;
    localparam int MODE_NOACK   = 1;
    localparam int MODE_NOCLOCK = 2;

    typedef struct {
        bit         is_done;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       parity;
        logic       stop;
    } rx_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic       tx_done_tick;
    logic       tx_error;
    logic       busy;
    logic       ps2_clock_drive_low;
    logic       ps2_data_drive_low;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       glitch_low   = 1'b0;
    logic       ps2_clock_in;
    logic       ps2_data_in;

    // Open-collector bus: any party pulling low wins.
    assign ps2_clock_in = ~(ps2_clock_drive_low | dev_clk_low | glitch_low);
    assign ps2_data_in  = ~(ps2_data_drive_low | dev_data_low);

    exp_t exp_q[$];
    rx_t  rx_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;
    bit   ready_chk = 1'b0;

    always #5 clk = ~clk;

    ps2_transmitter #(
        .CLK_FREQUENCY_HZ      (CLK_HZ),
        .INHIBIT_US            (INH_US),
        .FIRST_EDGE_TIMEOUT_US (FIRST_US),
        .FRAME_TIMEOUT_US      (FRAME_US),
        .FILTER_CYCLES         (FILT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .tx_data             (tx_data),
        .tx_start            (tx_start),
        .tx_ready            (tx_ready),
        .tx_done_tick        (tx_done_tick),
        .tx_error            (tx_error),
        .busy                (busy),
        .ps2_clock_in        (ps2_clock_in),
        .ps2_data_in         (ps2_data_in),
        .ps2_clock_drive_low (ps2_clock_drive_low),
        .ps2_data_drive_low  (ps2_data_drive_low)
    );

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!tx_ready && n < 20_000) begin
            @(negedge clk);
            n++;
        end
        ok = tx_ready;
        check(ok, "ready_wait", int'(tx_ready), 1);
    endtask

    // Behavioural device: after request-to-send, generate 11 clock pulses,
    // read bits on rising edges 1..10 and optionally acknowledge.
    task automatic run_device(input int mode, input int abort_edge,
                              input bit glitch, input bit hold_start);
        logic [9:0] bits;
        rx_t        r;
        bits = '0;
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (25) @(negedge clk);
            if (k == 3) check(busy == 1'b1, "busy_mid_frame", int'(busy), 1);
            if (k == abort_edge) begin
                check(busy == 1'b1, "busy_before_reset", int'(busy), 1);
                tx_start = 1'b0;
                reset    = 1'b1;
                #1;
                check(!ps2_clock_drive_low && !ps2_data_drive_low, "reset_release_lines",
                      int'({ps2_clock_drive_low, ps2_data_drive_low}), 0);
                check(tx_ready && !busy && !tx_done_tick && !tx_error, "reset_status",
                      int'({tx_ready, busy, tx_done_tick, tx_error}), 8);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                repeat (3) @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (hold_start && k == 5) tx_start = 1'b0;
            repeat (25) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k-1] = ps2_data_in;
            repeat (25) @(negedge clk);
            if (k == 10 && mode == MODE_ACK) dev_data_low = 1'b1;
            if (glitch && k < 10) begin
                glitch_low = 1'b1;
                repeat (3) @(negedge clk);
                glitch_low = 1'b0;
                repeat (22) @(negedge clk);
            end else begin
                repeat (25) @(negedge clk);
            end
        end
        dev_data_low = 1'b0;
        if (mode == MODE_ACK) begin
            r.data   = bits[7:0];
            r.parity = bits[8];
            r.stop   = bits[9];
            rx_q.push_back(r);
        end
    endtask

    task automatic send(input logic [7:0] d, input int mode, input int abort_edge,
                        input bit glitch, input bit hold_start);
        int   cnt;
        bit   ok;
        exp_t e;
        wait_ready(ok);
        if (!ok) return;
        tx_data  = d;
        tx_start = 1'b1;
        if (abort_edge == 0) begin
            e.is_done = (mode == MODE_ACK);
            e.data    = d;
            exp_q.push_back(e);
        end
        @(negedge clk);
        if (hold_start) tx_data = ~d;
        else            tx_start = 1'b0;
        cnt = 0;
        while (ps2_clock_drive_low && cnt < N_INHIBIT + 50) begin
            cnt++;
            @(negedge clk);
        end
        check(cnt >= N_INHIBIT - 1 && cnt <= N_INHIBIT + 1, "inhibit_len", cnt, N_INHIBIT);
        check(ps2_data_drive_low && !ps2_clock_drive_low, "request_to_send",
              int'({ps2_data_drive_low, ps2_clock_drive_low}), 2);
        if (mode == MODE_NOCLOCK) begin
            cnt = 0;
            while (!tx_error && cnt < 2 * M_FIRST) begin
                @(negedge clk);
                cnt++;
            end
            check(cnt == M_FIRST, "first_edge_timeout", cnt, M_FIRST);
        end else begin
            run_device(mode, abort_edge, glitch, hold_start);
        end
        tx_start = 1'b0;
        wait_ready(ok);
        repeat (5) @(negedge clk);
        $display("TXN %0d data=0x%02h mode=%0d abort_edge=%0d glitch=%0d hold=%0d",
                 txn, d, mode, abort_edge, glitch, hold_start);
        txn++;
    endtask

    // Monitor: every pulse consumes one expected outcome.
    always @(negedge clk) begin
        exp_t e;
        rx_t  r;
        if (reset) begin
            ready_chk = 1'b0;
        end else begin
            if (ready_chk) begin
                check(tx_ready && !tx_done_tick && !tx_error, "ready_after_pulse",
                      int'({tx_ready, tx_done_tick, tx_error}), 4);
                ready_chk = 1'b0;
            end
            if (tx_done_tick || tx_error) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_pulse", int'({tx_done_tick, tx_error}), 0);
                end else begin
                    e = exp_q.pop_front();
                    check(tx_done_tick == e.is_done && tx_error == !e.is_done, "pulse_kind",
                          int'({tx_done_tick, tx_error}), e.is_done ? 2 : 1);
                    if (e.is_done) begin
                        if (rx_q.size() == 0) begin
                            check(1'b0, "device_rx_missing", 0, 1);
                        end else begin
                            r = rx_q.pop_front();
                            check(r.data == e.data, "rx_byte", int'(r.data), int'(e.data));
                            check(r.parity == (($countones(e.data) % 2) == 0), "rx_parity",
                                  int'(r.parity), int'(($countones(e.data) % 2) == 0));
                            check(r.stop == 1'b1, "rx_stop", int'(r.stop), 1);
                        end
                    end else begin
                        check(!ps2_clock_drive_low && !ps2_data_drive_low, "error_lines_released",
                              int'({ps2_clock_drive_low, ps2_data_drive_low}), 0);
                    end
                end
                ready_chk = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        tx_data  = 8'h00;
        tx_start = 1'b0;
        repeat (3) @(negedge clk);
        check(tx_ready && !busy && !tx_done_tick && !tx_error, "reset_status",
              int'({tx_ready, busy, tx_done_tick, tx_error}), 8);
        check(!ps2_clock_drive_low && !ps2_data_drive_low, "reset_lines",
              int'({ps2_clock_drive_low, ps2_data_drive_low}), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send(8'hED, MODE_ACK,     0, 1'b1, 1'b1);   // glitches + held start
        send(8'h01, MODE_ACK,     0, 1'b0, 1'b0);
        send(8'h55, MODE_NOACK,   0, 1'b0, 1'b0);
        send(8'h00, MODE_NOCLOCK, 0, 1'b0, 1'b0);
        send(8'h3C, MODE_ACK,     5, 1'b0, 1'b0);   // reset at edge 5
        send(8'hF4, MODE_ACK,     0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            send(8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0) ? MODE_NOACK : MODE_ACK,
                 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // The held tx_start must not have spawned an extra frame.
        repeat (200) @(negedge clk);
        check(!ps2_clock_drive_low && tx_ready, "idle_at_end",
              int'({ps2_clock_drive_low, tx_ready}), 1);
        check(exp_q.size() == 0, "expected_drained", exp_q.size(), 0);
        check(rx_q.size() == 0, "rx_drained", rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
